data_ram_pipe: RTL and testbench

// Parametrised data-memory model for core-level simulation. Sits on the core data port (req/gnt/rvalid).

---
 rtl/tb_mem_pkg.sv | 13 +
 rtl/data_ram_pipe_if.sv | 29 ++
 rtl/lfsr8_stall.sv | 25 ++
 rtl/data_ram_pipe.sv | 124 ++++++++++++
 tb/tb_data_ram_pipe.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tb_mem_pkg.sv
// Shared types and constants for the data-port memory model.
// Response records carry a fixed maximum width; the top zero-extends into them.
package tb_mem_pkg;

  localparam int MEM_MAX_W = 128;
  localparam logic [31:0] TOHOST_PASS = 32'h1;

  typedef struct packed {
    logic                 err;
    logic [MEM_MAX_W-1:0] rdata;
  } mem_resp_t;

endpackage

// File: rtl/data_ram_pipe_if.sv
// Core data port (req/gnt/rvalid) bundle between a core master and a memory slave.
// Handshake: a request transfers on a cycle with data_req=1 and data_gnt=1; the master keeps
// req/addr/we/be/wdata stable until that cycle. Each transfer yields exactly one data_rvalid
// pulse later, in order, and the master must take it (there is no response backpressure).
interface data_ram_pipe_if #(
  parameter int DATA_W = 32
) ();

  logic                  data_req;
  logic                  data_gnt;
  logic [31:0]           data_addr;
  logic                  data_we;
  logic [DATA_W/8-1:0]   data_be;
  logic [DATA_W-1:0]     data_wdata;
  logic                  data_rvalid;
  logic [DATA_W-1:0]     data_rdata;
  logic                  data_err;

  modport master (
    output data_req, data_addr, data_we, data_be, data_wdata,
    input  data_gnt, data_rvalid, data_rdata, data_err
  );

  modport slave (
    input  data_req, data_addr, data_we, data_be, data_wdata,
    output data_gnt, data_rvalid, data_rdata, data_err
  );

endinterface

// File: rtl/lfsr8_stall.sv
// 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) whose low bit marks pseudo-random stall cycles.
module lfsr8_stall #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  output logic stall_o
);

  logic [7:0] r_lfsr;
  logic       w_fb;

  assign w_fb    = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
  assign stall_o = r_lfsr[0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_lfsr <= SEED;
    end else if (en_i) begin
      r_lfsr <= {r_lfsr[6:0], w_fb};
    end
  end

endmodule

// File: rtl/data_ram_pipe.sv
// Parametrised data memory on the core data port with fixed read latency, optional grant
// stalls, error responses and a sticky tohost test-status word. DATA_W must be >= 32.
module data_ram_pipe
  import tb_mem_pkg::*;
#(
  parameter int          DATA_W      = 32,
  parameter int          DEPTH       = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          RD_LATENCY  = 1,
  parameter int          STALL_EN    = 0,
  parameter logic [7:0]  LFSR_SEED   = 8'hA5,
  parameter logic [31:0] TOHOST_ADDR = 32'h8000_1000
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  data_ram_pipe_if.slave    bus,
  output logic              test_done_o,
  output logic              test_pass_o,
  output logic [30:0]       test_code_o
);

  localparam int BE_W  = DATA_W / 8;
  localparam int OFF_W = (BE_W > 1) ? $clog2(BE_W) : 0;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic              w_stall_raw;
  logic              w_stall;
  logic              w_accept;
  logic              w_below;
  logic [31:0]       w_off;
  logic [31:0]       w_word;
  logic              w_in_range;
  logic [IDX_W-1:0]  w_idx;
  logic              w_is_tohost;
  logic              w_tohost_wr;
  logic              w_mem_wr;
  mem_resp_t         w_resp;

  logic [DATA_W-1:0]     r_mem [DEPTH];
  mem_resp_t             r_pipe [RD_LATENCY];
  logic [RD_LATENCY-1:0] r_pipe_v;
  logic                  r_done;
  logic                  r_pass;
  logic [30:0]           r_code;

  lfsr8_stall #(.SEED(LFSR_SEED)) u_lfsr (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .en_i    (STALL_EN != 0),
    .stall_o (w_stall_raw)
  );

  assign w_stall      = (STALL_EN != 0) ? w_stall_raw : 1'b0;
  assign bus.data_gnt = bus.data_req & ~w_stall;
  assign w_accept     = bus.data_req & bus.data_gnt;

  // The borrow of the 33-bit subtraction flags addresses below the array base.
  assign {w_below, w_off} = {1'b0, bus.data_addr} - {1'b0, BASE_ADDR};
  assign w_word      = w_off >> OFF_W;
  assign w_in_range  = ~w_below && (w_word < 32'(DEPTH));
  assign w_idx       = w_word[IDX_W-1:0];
  assign w_is_tohost = (bus.data_addr == TOHOST_ADDR);
  assign w_tohost_wr = w_is_tohost & bus.data_we & (&bus.data_be);
  assign w_mem_wr    = w_accept & bus.data_we & w_in_range & ~w_is_tohost;

  always_comb begin
    w_resp = '0;
    if (w_is_tohost) begin
      // A partial-byte tohost write is neither a status update nor a memory access.
      if (!bus.data_we) begin
        w_resp.rdata = MEM_MAX_W'({r_code, r_pass});
      end else if (!w_tohost_wr) begin
        w_resp.err = 1'b1;
      end
    end else if (!w_in_range) begin
      w_resp.err = 1'b1;
    end else if (!bus.data_we) begin
      w_resp.rdata = MEM_MAX_W'(r_mem[w_idx]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_mem_wr) begin
      for (int b = 0; b < BE_W; b++) begin
        if (bus.data_be[b]) begin
          r_mem[w_idx][8*b +: 8] <= bus.data_wdata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pipe_v <= '0;
      for (int s = 0; s < RD_LATENCY; s++) begin
        r_pipe[s] <= '0;
      end
      r_done <= 1'b0;
      r_pass <= 1'b0;
      r_code <= '0;
    end else begin
      r_pipe_v[0] <= w_accept;
      r_pipe[0]   <= w_accept ? w_resp : '0;
      for (int s = 1; s < RD_LATENCY; s++) begin
        r_pipe_v[s] <= r_pipe_v[s-1];
        r_pipe[s]   <= r_pipe[s-1];
      end
      // Only the first tohost result is kept until the next reset.
      if (w_accept && w_tohost_wr && !r_done) begin
        r_done <= 1'b1;
        r_pass <= (bus.data_wdata == DATA_W'(TOHOST_PASS));
        r_code <= bus.data_wdata[31:1];
      end
    end
  end

  assign bus.data_rvalid = r_pipe_v[RD_LATENCY-1];
  assign bus.data_err    = r_pipe[RD_LATENCY-1].err;
  assign bus.data_rdata  = r_pipe[RD_LATENCY-1].rdata[DATA_W-1:0];
  assign test_done_o     = r_done;
  assign test_pass_o     = r_pass;
  assign test_code_o     = r_code;

endmodule

// File: tb/tb_data_ram_pipe.sv
// Bench for data_ram_pipe: three configurations share one request driver selected by sel;
// responses are scored against a word-array reference model of the memory and tohost word.
module tb_data_ram_pipe;

  localparam int          DEPTH  = 64;
  localparam logic [31:0] BASE2  = 32'h0000_1000;
  localparam logic [31:0] TOHOST = 32'h8000_1000;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
    logic [31:0] cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] cyc = '0;
  int          sel = 0;
  logic        mon_en = 1'b0;

  logic        d_req = 1'b0;
  logic [31:0] d_addr = '0;
  logic        d_we = 1'b0;
  logic [3:0]  d_be = '0;
  logic [31:0] d_wdata = '0;

  logic        o_gnt [3];
  logic        o_rvalid [3];
  logic        o_err [3];
  logic [31:0] o_rdata [3];
  logic        o_done [3];
  logic        o_pass [3];
  logic [30:0] o_code [3];
  logic        m_gnt, m_rvalid, m_err, m_done, m_pass;
  logic [31:0] m_rdata;
  logic [30:0] m_code;

  exp_t        exp_q [$];
  logic [31:0] mdl_mem [3][DEPTH];
  logic        mdl_done [3];
  logic        mdl_pass [3];
  logic [30:0] mdl_code [3];

  int          n_vec = 0;
  int          n_fail = 0;
  int          acc_cnt = 0;
  int          resp_cnt = 0;
  int          stall_cnt = 0;
  logic [31:0] last_rdata = '0;
  logic        mon_due;
  exp_t        mon_e;

  data_ram_pipe_if #(.DATA_W(32)) if0 ();
  data_ram_pipe_if #(.DATA_W(32)) if1 ();
  data_ram_pipe_if #(.DATA_W(32)) if2 ();

  assign if0.data_req = d_req && (sel == 0);
  assign if1.data_req = d_req && (sel == 1);
  assign if2.data_req = d_req && (sel == 2);
  assign if0.data_addr = d_addr;  assign if1.data_addr = d_addr;  assign if2.data_addr = d_addr;
  assign if0.data_we = d_we;      assign if1.data_we = d_we;      assign if2.data_we = d_we;
  assign if0.data_be = d_be;      assign if1.data_be = d_be;      assign if2.data_be = d_be;
  assign if0.data_wdata = d_wdata; assign if1.data_wdata = d_wdata; assign if2.data_wdata = d_wdata;

  assign o_gnt[0] = if0.data_gnt;       assign o_gnt[1] = if1.data_gnt;       assign o_gnt[2] = if2.data_gnt;
  assign o_rvalid[0] = if0.data_rvalid; assign o_rvalid[1] = if1.data_rvalid; assign o_rvalid[2] = if2.data_rvalid;
  assign o_err[0] = if0.data_err;       assign o_err[1] = if1.data_err;       assign o_err[2] = if2.data_err;
  assign o_rdata[0] = if0.data_rdata;   assign o_rdata[1] = if1.data_rdata;   assign o_rdata[2] = if2.data_rdata;

  data_ram_pipe #(.DEPTH(DEPTH), .BASE_ADDR(32'h0), .RD_LATENCY(3), .STALL_EN(0),
                  .TOHOST_ADDR(TOHOST)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .bus(if0),
    .test_done_o(o_done[0]), .test_pass_o(o_pass[0]), .test_code_o(o_code[0]));
  data_ram_pipe #(.DEPTH(DEPTH), .BASE_ADDR(32'h0), .RD_LATENCY(2), .STALL_EN(0),
                  .TOHOST_ADDR(TOHOST)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .bus(if1),
    .test_done_o(o_done[1]), .test_pass_o(o_pass[1]), .test_code_o(o_code[1]));
  data_ram_pipe #(.DEPTH(DEPTH), .BASE_ADDR(BASE2), .RD_LATENCY(2), .STALL_EN(1),
                  .LFSR_SEED(8'hA5), .TOHOST_ADDR(TOHOST)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n), .bus(if2),
    .test_done_o(o_done[2]), .test_pass_o(o_pass[2]), .test_code_o(o_code[2]));

  always_comb begin
    m_gnt    = o_gnt[sel];
    m_rvalid = o_rvalid[sel];
    m_err    = o_err[sel];
    m_rdata  = o_rdata[sel];
    m_done   = o_done[sel];
    m_pass   = o_pass[sel];
    m_code   = o_code[sel];
  end

  // Clock / reset plumbing
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic int lat_of(input int s);
    return (s == 0) ? 3 : 2;
  endfunction

  function automatic logic [31:0] base_of(input int s);
    return (s == 2) ? BASE2 : 32'h0;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: one accepted request, using the currently driven fields.
  task automatic model_accept();
    exp_t        e;
    int          s;
    logic [31:0] b;
    logic [31:0] word;
    s = sel;
    b = base_of(s);
    e.err = 1'b0;
    e.rdata = '0;
    e.cyc = cyc + 32'(lat_of(s));
    if (d_addr == TOHOST) begin
      if (!d_we) e.rdata = {mdl_code[s], mdl_pass[s]};
      else if (d_be != 4'hF) e.err = 1'b1;
      else if (!mdl_done[s]) begin
        mdl_done[s] = 1'b1;
        mdl_pass[s] = (d_wdata == 32'd1);
        mdl_code[s] = d_wdata[31:1];
      end
    end else if (d_addr < b || (d_addr - b) / 4 >= DEPTH) begin
      e.err = 1'b1;
    end else begin
      word = (d_addr - b) / 4;
      if (d_we) begin
        for (int k = 0; k < 4; k++)
          if (d_be[k]) mdl_mem[s][word[5:0]][8*k +: 8] = d_wdata[8*k +: 8];
      end else begin
        e.rdata = mdl_mem[s][word[5:0]];
      end
    end
    exp_q.push_back(e);
  endtask

  // Scoreboard: every cycle, rvalid must match whether a response is due now.
  always @(negedge clk) begin
    if (mon_en) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) void'(exp_q.pop_front());
      mon_due = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
      chk("rvalid", 64'(m_rvalid), 64'(mon_due));
      if (m_rvalid) begin
        resp_cnt++;
        last_rdata = m_rdata;
      end
      if (mon_due) begin
        mon_e = exp_q.pop_front();
        chk("rdata", 64'(m_rdata), 64'(mon_e.rdata));
        chk("err", 64'(m_err), 64'(mon_e.err));
      end
    end
  end

  // Driver: called just after a rising edge; returns just after the accept edge.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [3:0] be,
                        input logic [31:0] wdata);
    int   waited;
    logic got;
    waited = 0;
    got = 1'b0;
    d_we = we; d_addr = addr; d_be = be; d_wdata = wdata; d_req = 1'b1;
    while (!got && waited < 64) begin
      @(negedge clk);
      if (sel != 2) chk("gnt", 64'(m_gnt), 64'(1));
      if (m_gnt) begin
        model_accept();
        acc_cnt++;
        got = 1'b1;
      end else begin
        stall_cnt++;
        waited++;
      end
      @(posedge clk); #1;
    end
    d_req = 1'b0;
    n_vec++;
    assert (got) else begin
      n_fail++;
      $error("FAIL gnt_wait: observed no grant after %0d cycles, expected grant", waited);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    n_vec++;
    assert (exp_q.size() == 0) else begin
      n_fail++;
      $error("FAIL drain: observed %0d responses outstanding, expected 0", exp_q.size());
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    d_req = 1'b0;
    exp_q.delete();
    for (int s = 0; s < 3; s++) begin
      mdl_done[s] = 1'b0; mdl_pass[s] = 1'b0; mdl_code[s] = '0;
    end
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      chk("rst_flags", {60'd0, o_gnt[s], o_rvalid[s], o_err[s], o_done[s] | o_pass[s]}, 64'd0);
      chk("rst_data", {1'b0, o_code[s], o_rdata[s]}, 64'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] a;
    int          r;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    mon_en = 1'b1;

    // Reset with two reads in flight: both responses must vanish.
    sel = 0;
    do_req(1'b0, 32'h4, 4'hF, '0);
    do_req(1'b0, 32'h8, 4'hF, '0);
    do_reset();
    repeat (8) @(posedge clk);
    #1;

    // Byte-enable merge, then a read accepted right after a write to the same word.
    do_req(1'b1, 32'h14, 4'hF, 32'hFFFF_FFFF);
    do_req(1'b1, 32'h14, 4'b0101, 32'h1122_3344);
    do_req(1'b0, 32'h14, 4'hF, '0);
    drain();
    chk("word5_merge", 64'(last_rdata), 64'(32'hFF22_FF44));
    do_req(1'b1, 32'h18, 4'hF, 32'hCAFE_F00D);
    do_req(1'b0, 32'h18, 4'hF, '0);
    drain();

    // Latency 2: four back-to-back reads, low address bits ignored.
    sel = 1;
    for (int i = 0; i < 4; i++) do_req(1'b1, 32'(i * 4), 4'hF, $urandom);
    drain();
    for (int i = 0; i < 4; i++) do_req(1'b0, 32'(i * 4) + 32'($urandom_range(0, 3)), 4'hF, '0);
    drain();

    // Out-of-range read/write; aliasing word 0 must stay untouched.
    do_req(1'b0, 32'(DEPTH * 4), 4'hF, '0);
    do_req(1'b1, 32'(DEPTH * 4), 4'hF, 32'hDEAD_BEEF);
    do_req(1'b0, 32'h0, 4'hF, '0);
    do_req(1'b0, 32'hFFFF_FFF0, 4'hF, '0);
    drain();

    // Tohost: first result sticks, partial writes error, readback is {code,pass}.
    sel = 0;
    do_req(1'b1, TOHOST, 4'hF, 32'd1);
    @(negedge clk);
    chk("tohost_done", 64'(m_done), 64'(1));
    chk("tohost_pass", 64'(m_pass), 64'(1));
    @(posedge clk); #1;
    do_req(1'b1, TOHOST, 4'hF, 32'd7);
    @(negedge clk);
    chk("tohost_keep_pass", 64'(m_pass), 64'(1));
    chk("tohost_keep_code", 64'(m_code), 64'(0));
    @(posedge clk); #1;
    do_req(1'b0, TOHOST, 4'hF, '0);
    do_req(1'b1, TOHOST, 4'b0011, 32'd9);
    drain();
    do_reset();
    do_req(1'b1, TOHOST, 4'hF, 32'd7);
    @(negedge clk);
    chk("fresh_done", 64'(m_done), 64'(1));
    chk("fresh_pass", 64'(m_pass), 64'(0));
    chk("fresh_code", 64'(m_code), 64'(3));
    @(posedge clk); #1;
    do_req(1'b0, TOHOST, 4'hF, '0);
    drain();
    chk("tohost_read", 64'(last_rdata), 64'(6));

    // Stalling instance: fill the array, then random traffic.
    sel = 2;
    for (int i = 0; i < DEPTH; i++) do_req(1'b1, BASE2 + 32'(i * 4), 4'hF, $urandom);
    drain();
    acc_cnt = 0;
    resp_cnt = 0;
    stall_cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      r = $urandom_range(0, 15);
      if (r == 0)      a = TOHOST;
      else if (r == 1) a = 32'($urandom_range(0, 32'(BASE2) - 1));
      else if (r == 2) a = BASE2 + 32'(DEPTH * 4) + 32'($urandom_range(0, 1000));
      else             a = BASE2 + 32'($urandom_range(0, DEPTH - 1) * 4) + 32'($urandom_range(0, 3));
      do_req(1'($urandom_range(0, 1)), a,
             (r == 0 && $urandom_range(0, 3) != 0) ? 4'hF : 4'($urandom_range(0, 15)), $urandom);
    end
    drain();
    chk("resp_count", 64'(resp_cnt), 64'(acc_cnt));
    n_vec++;
    assert (stall_cnt > 0) else begin
      n_fail++;
      $error("FAIL stall_seen: observed %0d stall cycles, expected at least 1", stall_cnt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
